// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder.
//
// Holds the FSM state encoding, the command opcodes, the acknowledge bytes
// and the PSRAM address/data widths.
//
// Configuration macro: UART_CMD_DECODER_CMD_ACK_EN
//   When defined, the TX_ACK state exists. The decoder then answers accepted
//   writes with 'W' and unknown opcodes with '?'.

package uart_cmd_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    localparam logic [7:0] OP_READ  = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;

    localparam logic [7:0] ACK_WRITE = 8'h57;
    localparam logic [7:0] ACK_BAD   = 8'h3F;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR0   = 4'd1,
        ADDR1   = 4'd2,
        ADDR2   = 4'd3,
        DATA0   = 4'd4,
        DATA1   = 4'd5,
        ISSUE   = 4'd6,
        WAIT_RD = 4'd7,
        TX_LO   = 4'd8,
        TX_HI   = 4'd9
`ifdef UART_CMD_DECODER_CMD_ACK_EN
        ,
        TX_ACK  = 4'd10
`endif
    } state_t;

endpackage

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns a byte stream into PSRAM requests.
//
// Command format (LSB first):
//   write: 0x01 a[7:0] a[15:8] a[23:16] d[7:0] d[15:8]
//   read : 0x00 a[7:0] a[15:8] a[23:16]
// A read returns its 16-bit data on TX, low byte first.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   i_rx_valid/data one-cycle strobe carrying a received byte
//   o_tx_valid/data TX byte, held until i_tx_ready
//   o_mem_req       PSRAM request, held until i_mem_ready
//   o_mem_we/addr/wdata  request fields, stable while o_mem_req is high
//   i_mem_rvalid/rdata   read data return strobe
//   o_busy          high whenever the FSM is not IDLE
//   o_overrun       sticky flag: an RX byte arrived while it could not be taken
//
// Configuration macro: UART_CMD_DECODER_CMD_ACK_EN (adds the TX_ACK state)

module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_mem_req,
    input  logic              i_mem_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  idle_cnt;
    logic              collecting;
    logic              timeout_hit;
    logic              opcode_ok;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              overrun_q;
`ifdef UART_CMD_DECODER_CMD_ACK_EN
    logic [7:0]        ack_q;
`endif

    // The inter-byte timeout only applies while a command is being assembled.
    assign collecting  = (state == ADDR0) || (state == ADDR1) || (state == ADDR2) ||
                         (state == DATA0) || (state == DATA1);
    assign timeout_hit = collecting && !i_rx_valid && (idle_cnt == CNT_LAST);
    assign opcode_ok   = (i_rx_data == OP_WRITE) || (i_rx_data == OP_READ);

    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_busy      = (state != IDLE);
    assign o_overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_mem_req  = 1'b0;

        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    if (opcode_ok) begin
                        state_next = ADDR0;
                    end else begin
`ifdef UART_CMD_DECODER_CMD_ACK_EN
                        state_next = TX_ACK;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
            ADDR0: begin
                if (i_rx_valid) begin
                    state_next = ADDR1;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            ADDR1: begin
                if (i_rx_valid) begin
                    state_next = ADDR2;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            ADDR2: begin
                if (i_rx_valid) begin
                    state_next = we_q ? DATA0 : ISSUE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DATA0: begin
                if (i_rx_valid) begin
                    state_next = DATA1;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DATA1: begin
                if (i_rx_valid) begin
                    state_next = ISSUE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    if (we_q) begin
`ifdef UART_CMD_DECODER_CMD_ACK_EN
                        state_next = TX_ACK;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (i_mem_rvalid) begin
                    state_next = TX_LO;
                end
            end
            TX_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = rdata_q[7:0];
                if (i_tx_ready) begin
                    state_next = TX_HI;
                end
            end
            TX_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = rdata_q[15:8];
                if (i_tx_ready) begin
                    state_next = IDLE;
                end
            end
`ifdef UART_CMD_DECODER_CMD_ACK_EN
            TX_ACK: begin
                o_tx_valid = 1'b1;
                o_tx_data  = ack_q;
                if (i_tx_ready) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte capture, timeout counter and overrun flag. Captured fields are
    // only ever written from RX bytes in the matching collection state, so
    // they stay stable for the whole ISSUE handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
`ifdef UART_CMD_DECODER_CMD_ACK_EN
            ack_q     <= 8'h00;
`endif
        end else begin
            if (!collecting || i_rx_valid || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            if (i_rx_valid) begin
                case (state)
                    IDLE: begin
                        if (opcode_ok) begin
                            we_q <= (i_rx_data == OP_WRITE);
                        end
`ifdef UART_CMD_DECODER_CMD_ACK_EN
                        ack_q <= opcode_ok ? ACK_WRITE : ACK_BAD;
`endif
                    end
                    ADDR0:   addr_q[7:0]    <= i_rx_data;
                    ADDR1:   addr_q[15:8]   <= i_rx_data;
                    ADDR2:   addr_q[23:16]  <= i_rx_data;
                    DATA0:   wdata_q[7:0]   <= i_rx_data;
                    DATA1:   wdata_q[15:8]  <= i_rx_data;
                    default: overrun_q      <= 1'b1;
                endcase
            end

            // Read data outside WAIT_RD is stale or spurious and is ignored.
            if (state == WAIT_RD && i_mem_rvalid) begin
                rdata_q <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for uart_cmd_decoder.
// Directed scenarios followed by randomized commands; expected requests and
// TX bytes come from a command-level model of the byte protocol.
// Honours UART_CMD_DECODER_CMD_ACK_EN in the same way as the design.

module tb_uart_cmd_decoder;

    localparam int TO_CYC = 40;
`ifdef UART_CMD_DECODER_CMD_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  o_tx_data;
    logic        o_mem_req;
    logic        i_mem_ready;
    logic        o_mem_we;
    logic [23:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [15:0] i_mem_rdata;
    logic        o_busy;
    logic        o_overrun;

    int total = 0;
    int bad   = 0;

    // responder controls
    bit          mem_rand = 1'b0;
    bit          tx_rand  = 1'b0;
    bit          tx_hold  = 1'b0;
    logic [15:0] rd_value = 16'h0000;
    int          rd_delay = 5;
    bit          rd_pending = 1'b0;
    int          rd_count = 0;
    int          mem_unstable = 0;
    int          tx_unstable = 0;
    bit          prev_req_wait = 1'b0;
    logic [40:0] prev_req = '0;
    bit          prev_tx_wait = 1'b0;
    logic [7:0]  prev_tx = 8'h00;

    // stimulus, expected and observed traffic; requests packed {we, addr, wdata}
    logic [7:0]  stim_q[$];
    logic [40:0] exp_req_q[$];
    logic [40:0] obs_req_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  obs_tx_q[$];

    uart_cmd_decoder #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_mem_req   (o_mem_req),
        .i_mem_ready (i_mem_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    initial forever #5 clk = ~clk;

    // PSRAM and UART TX partner. Everything happens on the falling edge:
    // ready decisions made here are what the DUT sees at the next rising edge,
    // so a valid&ready pair seen here is the transfer at that edge.
    initial begin
        i_mem_ready  = 1'b0;
        i_tx_ready   = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            i_mem_ready = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_tx_ready  = tx_hold ? 1'b0 : (tx_rand ? 1'($urandom_range(0, 1)) : 1'b1);

            if (rd_pending && rd_count == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rd_value;
                rd_pending   = 1'b0;
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = 16'($urandom);
                if (rd_pending) rd_count--;
            end

            if (prev_req_wait && (!o_mem_req || {o_mem_we, o_mem_addr, o_mem_wdata} != prev_req))
                mem_unstable++;
            if (prev_tx_wait && (!o_tx_valid || o_tx_data != prev_tx))
                tx_unstable++;

            if (o_mem_req && i_mem_ready) begin
                obs_req_q.push_back({o_mem_we, o_mem_addr, o_mem_wdata});
                if (!o_mem_we) begin
                    rd_pending = 1'b1;
                    rd_count   = rd_delay;
                end
            end
            if (o_tx_valid && i_tx_ready) obs_tx_q.push_back(o_tx_data);

            prev_req_wait = o_mem_req && !i_mem_ready && !rst;
            prev_req      = {o_mem_we, o_mem_addr, o_mem_wdata};
            prev_tx_wait  = o_tx_valid && !i_tx_ready && !rst;
            prev_tx       = o_tx_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Send stim_q, one byte per strobe, with up to gap_max idle cycles between.
    task automatic applyStimulus(input int gap_max);
        foreach (stim_q[i]) begin
            @(negedge clk);
            i_rx_valid = 1'b1;
            i_rx_data  = stim_q[i];
            @(negedge clk);
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom);
            if (gap_max > 0 && i + 1 < stim_q.size())
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    // Command-level model: what a complete byte sequence must produce.
    task automatic buildExpected();
        exp_req_q.delete();
        exp_tx_q.delete();
        if (stim_q.size() == 0) return;
        if (stim_q[0] == 8'h01 && stim_q.size() >= 6) begin
            exp_req_q.push_back({1'b1, stim_q[3], stim_q[2], stim_q[1], stim_q[5], stim_q[4]});
            if (ACK_EN) exp_tx_q.push_back(8'h57);
        end else if (stim_q[0] == 8'h00 && stim_q.size() >= 4) begin
            exp_req_q.push_back({1'b0, stim_q[3], stim_q[2], stim_q[1], 16'h0000});
            exp_tx_q.push_back(rd_value[7:0]);
            exp_tx_q.push_back(rd_value[15:8]);
        end else if (stim_q[0] > 8'h01) begin
            if (ACK_EN) exp_tx_q.push_back(8'h3F);
        end
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        checkOutput({tag, " back to idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic checkCommand(input string tag);
        logic [40:0] e;
        logic [40:0] o;
        checkOutput({tag, " req count"}, obs_req_q.size(), exp_req_q.size());
        for (int i = 0; i < exp_req_q.size() && i < obs_req_q.size(); i++) begin
            e = exp_req_q[i];
            o = obs_req_q[i];
            checkOutput({tag, " we"}, 32'(o[40]), 32'(e[40]));
            checkOutput({tag, " addr"}, 32'(o[39:16]), 32'(e[39:16]));
            if (e[40]) checkOutput({tag, " wdata"}, 32'(o[15:0]), 32'(e[15:0]));
        end
        checkOutput({tag, " tx count"}, obs_tx_q.size(), exp_tx_q.size());
        for (int i = 0; i < exp_tx_q.size() && i < obs_tx_q.size(); i++)
            checkOutput({tag, " tx byte"}, 32'(obs_tx_q[i]), 32'(exp_tx_q[i]));
        obs_req_q.delete();
        obs_tx_q.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " tx_valid"}, 32'(o_tx_valid), 32'd0);
        checkOutput({tag, " tx_data"},  32'(o_tx_data),  32'd0);
        checkOutput({tag, " mem_req"},  32'(o_mem_req),  32'd0);
        checkOutput({tag, " mem_we"},   32'(o_mem_we),   32'd0);
        checkOutput({tag, " mem_addr"}, 32'(o_mem_addr), 32'd0);
        checkOutput({tag, " wdata"},    32'(o_mem_wdata), 32'd0);
        checkOutput({tag, " busy"},     32'(o_busy),     32'd0);
        checkOutput({tag, " overrun"},  32'(o_overrun),  32'd0);
    endtask

    initial begin
        int kind;
        rst        = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        $display("[TB] start, ACK_EN=%0d", ACK_EN);

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // directed write
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h07};
        buildExpected();
        applyStimulus(0);
        checkOutput("wr req next cycle", 32'(o_mem_req), 32'd1);
        waitIdle("wr");
        checkCommand("wr");

        // directed read, data five cycles after the request
        rd_value = 16'h0708;
        rd_delay = 5;
        stim_q = '{8'h00, 8'h02, 8'h03, 8'h04};
        buildExpected();
        applyStimulus(0);
        checkOutput("rd req next cycle", 32'(o_mem_req), 32'd1);
        waitIdle("rd");
        checkCommand("rd");

        // unknown opcode
        stim_q = '{8'h55};
        buildExpected();
        applyStimulus(0);
        repeat (3) @(negedge clk);
        waitIdle("bad op");
        checkCommand("bad op");

        // inter-byte timeout, then a normal write
        stim_q = '{8'h01, 8'h02};
        applyStimulus(0);
        repeat (TO_CYC / 2) @(negedge clk);
        checkOutput("timeout still waiting", 32'(o_busy), 32'd1);
        repeat (TO_CYC) @(negedge clk);
        checkOutput("timeout idle", 32'(o_busy), 32'd0);
        checkOutput("timeout no req", obs_req_q.size(), 32'd0);
        stim_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h34, 8'h12};
        buildExpected();
        applyStimulus(0);
        waitIdle("after timeout");
        checkCommand("after timeout");

        // read with TX back-pressure and a stray RX byte during WAIT_RD
        checkOutput("overrun clear", 32'(o_overrun), 32'd0);
        tx_hold  = 1'b1;
        rd_value = 16'h0708;
        rd_delay = 3;
        stim_q = '{8'h00, 8'h02, 8'h03, 8'h04};
        buildExpected();
        applyStimulus(0);
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h01;
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat (17) @(negedge clk);
        checkOutput("hold tx_valid", 32'(o_tx_valid), 32'd1);
        checkOutput("hold tx_data", 32'(o_tx_data), 32'h08);
        checkOutput("overrun set", 32'(o_overrun), 32'd1);
        tx_hold = 1'b0;
        waitIdle("backpressure");
        checkCommand("backpressure");
        checkOutput("overrun sticky", 32'(o_overrun), 32'd1);

        // reset in the middle of a write (in DATA0)
        stim_q = '{8'h01, 8'h11, 8'h22, 8'h33};
        applyStimulus(0);
        checkOutput("in data0 busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("mid reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("mid reset no req", obs_req_q.size(), 32'd0);
        checkOutput("mid reset no tx", obs_tx_q.size(), 32'd0);

        // randomized commands with random handshake timing
        mem_rand = 1'b1;
        tx_rand  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            kind     = $urandom_range(0, 2);
            rd_value = 16'($urandom);
            rd_delay = $urandom_range(0, 8);
            stim_q.delete();
            if (kind == 2) begin
                stim_q.push_back(8'($urandom_range(2, 255)));
            end else begin
                stim_q.push_back(kind == 1 ? 8'h01 : 8'h00);
                for (int b = 0; b < (kind == 1 ? 5 : 3); b++)
                    stim_q.push_back(8'($urandom));
            end
            buildExpected();
            applyStimulus(3);
            waitIdle("random");
            checkCommand("random");
        end

        checkOutput("mem fields held", mem_unstable, 32'd0);
        checkOutput("tx data held", tx_unstable, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100_000, SHALL set the inter-byte timeout in clk cycles (10 ms at 10 MHz).
REQ-002 clk  input  1  SHALL be the single clock; all logic rising-edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 i_rx_valid  input  1  SHALL be a one-cycle strobe marking a received UART byte.
REQ-005 i_rx_data  input  8  SHALL be the received byte, valid with i_rx_valid.
REQ-006 o_tx_valid / i_tx_ready / o_tx_data  out/in/out  1/1/8  SHALL form the UART TX byte handshake; a byte transfers on valid&ready.
REQ-007 o_mem_req / i_mem_ready  out/in  1/1  SHALL form the PSRAM controller request handshake; a request transfers on req&ready.
REQ-008 o_mem_we  output  1  SHALL be 1 for a write request and 0 for a read request.
REQ-009 o_mem_addr  output  24  SHALL carry the request address.
REQ-010 o_mem_wdata  output  16  SHALL carry the write data.
REQ-011 i_mem_rvalid / i_mem_rdata  input  1/16  SHALL return read data as a one-cycle strobe.
REQ-012 o_busy  output  1  SHALL be high in every state except IDLE.
REQ-013 o_overrun  output  1  SHALL be a sticky flag set by any dropped RX byte.

Function
REQ-014 FSM states SHALL be IDLE, ADDR0, ADDR1, ADDR2, DATA0, DATA1, ISSUE, WAIT_RD, TX_LO, TX_HI, TX_ACK.
REQ-015 In IDLE, an RX byte 0x01 SHALL select write, 0x00 read, then ADDR0; any other value SHALL be discarded (TX_ACK with 0x3F if CMD_ACK_EN, else stay IDLE).
REQ-016 Address bytes SHALL arrive LSB first: ADDR0->[7:0], ADDR1->[15:8], ADDR2->[23:16].
REQ-017 After ADDR2, a write SHALL go to DATA0 (wdata[7:0]) then DATA1 (wdata[15:8]), then ISSUE; a read SHALL go directly to ISSUE.
REQ-018 o_mem_req SHALL assert the cycle after the final command byte and hold, with stable we/addr/wdata, until i_mem_ready; exactly one request per command.
REQ-019 On acceptance, a write SHALL go to TX_ACK (CMD_ACK_EN) or IDLE; a read SHALL go to WAIT_RD.
REQ-020 WAIT_RD SHALL capture i_mem_rdata on i_mem_rvalid and go to TX_LO; rvalid outside WAIT_RD SHALL be ignored.
REQ-021 TX_LO SHALL send rdata[7:0], TX_HI rdata[15:8], each holding o_tx_valid and data until i_tx_ready; TX_HI then goes to IDLE.
REQ-022 In ADDR0..DATA1 a counter SHALL reset on every accepted byte; reaching TIMEOUT_CYC-1 cycles without a byte SHALL return to IDLE with no request issued.
REQ-023 An RX byte arriving in ISSUE, WAIT_RD, TX_LO, TX_HI or TX_ACK SHALL be dropped and set o_overrun.
REQ-024 i_rx_valid and i_tx_ready in the same cycle SHALL both be honoured independently.

Reset
REQ-025 rst SHALL force IDLE, clear the timeout counter, o_overrun, all captured fields, and drive o_tx_valid=0, o_tx_data=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0.
REQ-026 rst mid-command or mid-transfer SHALL abandon it with no further request or TX byte issued.

Configuration
REQ-027 Macro UART_CMD_DECODER_CMD_ACK_EN defined: accepted writes SHALL send 0x57 ('W') and bad opcodes 0x3F ('?') via TX_ACK; undefined: TX_ACK SHALL not exist and neither byte is sent.

Structure
REQ-028 Package uart_cmd_pkg SHALL hold the state enum, opcode constants (OP_READ=8'h00, OP_WRITE=8'h01), ACK constants (8'h57, 8'h3F) and the 24/16-bit address/data widths.
REQ-029 No sub-module; FSM, timeout counter and byte capture SHALL be flat in uart_cmd_decoder.

Verification
REQ-030 RX 01,02,03,04,08,07 -> one req with we=1, addr=24'h040302, wdata=16'h0708; with ACK_EN, TX byte 0x57.
REQ-031 RX 00,02,03,04; rdata=16'h0708 after 5 cycles -> one req we=0 addr=24'h040302, TX bytes 0x08 then 0x07.
REQ-032 RX 01,02 then TIMEOUT_CYC idle cycles -> IDLE, no req; then full write command succeeds normally.
REQ-033 RX 0x55 -> no req; with ACK_EN, TX 0x3F; without, no TX.
REQ-034 Read with i_tx_ready low for 20 cycles and an extra RX byte during WAIT_RD -> TX data held stable, o_overrun=1, bytes still 0x08,0x07.
REQ-035 rst asserted in DATA0 -> all outputs at reset values next cycle; no req issued.
